// File: rtl/fft_pkg.sv
// Shared FFT constants, sample types and the butterfly-stage FSM encoding.
package fft_pkg;

    localparam int N_FFT           = 512;
    localparam int ARRAY_IN        = 16;
    localparam int FRAME_CLK       = 32;
    localparam int CBFP0_WIDTH_OUT = 11;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH
    } bfly_state_e;

    typedef logic signed [CBFP0_WIDTH_OUT-1:0] sample11_t;
    typedef logic signed [CBFP0_WIDTH_OUT:0]   sample12_t;

    // Slot index width; a distance of one still gets a 1-bit index so no port collapses to zero width.
    function automatic int slotBits(input int d);
        return (d > 1) ? $clog2(d) : 1;
    endfunction

endpackage

// File: rtl/fft_bfly_sdf_stage_if.sv
// Sample-stream bundle between the CBFP normaliser, the butterfly stage and the twiddle stage.
interface fft_bfly_sdf_stage_if #(
    parameter int WIDTH_IN  = fft_pkg::CBFP0_WIDTH_OUT,
    parameter int WIDTH_OUT = WIDTH_IN + 1,
    parameter int ARRAY_IN  = fft_pkg::ARRAY_IN
);
    logic                        i_valid;
    logic signed [WIDTH_IN-1:0]  din_i [ARRAY_IN];
    logic signed [WIDTH_IN-1:0]  din_q [ARRAY_IN];
    logic                        dout_valid;
    logic signed [WIDTH_OUT-1:0] dout_i [ARRAY_IN];
    logic signed [WIDTH_OUT-1:0] dout_q [ARRAY_IN];
    logic                        frame_done;

    modport master (
        output i_valid, din_i, din_q,
        input  dout_valid, dout_i, dout_q, frame_done
    );

    modport slave (
        input  i_valid, din_i, din_q,
        output dout_valid, dout_i, dout_q, frame_done
    );
endinterface

// File: rtl/fft_bfly_lane.sv
// One lane of the SDF butterfly: per-slot delay buffer plus add/sub for I and Q.
module fft_bfly_lane #(
    parameter int WIDTH_IN  = 11,
    parameter int WIDTH_OUT = 12,
    parameter int D_CLK     = 4,
    parameter int SW        = fft_pkg::slotBits(D_CLK)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        phase_i,
    input  logic [SW-1:0]               slot_i,
    input  logic                        valid_i,
    input  logic                        emit_i,
    input  logic signed [WIDTH_IN-1:0]  xI_i,
    input  logic signed [WIDTH_IN-1:0]  xQ_i,
    output logic signed [WIDTH_OUT-1:0] yI_o,
    output logic signed [WIDTH_OUT-1:0] yQ_o
);
    localparam int DEPTH = 1 << SW;

    logic signed [WIDTH_OUT-1:0] bufI_q [DEPTH];
    logic signed [WIDTH_OUT-1:0] bufQ_q [DEPTH];
    logic signed [WIDTH_OUT-1:0] xI, xQ, bI, bQ;
    logic signed [WIDTH_OUT-1:0] yI_q, yQ_q;

    assign xI = {{(WIDTH_OUT-WIDTH_IN){xI_i[WIDTH_IN-1]}}, xI_i};
    assign xQ = {{(WIDTH_OUT-WIDTH_IN){xQ_i[WIDTH_IN-1]}}, xQ_i};
    assign bI = bufI_q[slot_i];
    assign bQ = bufQ_q[slot_i];

    // First half parks x; second half swaps x for the difference, which drains on the next first half or flush.
    always_ff @(posedge clk) begin
        if (valid_i) begin
            bufI_q[slot_i] <= phase_i ? bI - xI : xI;
            bufQ_q[slot_i] <= phase_i ? bQ - xQ : xQ;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            yI_q <= '0;
            yQ_q <= '0;
        end else if (valid_i && phase_i) begin
            yI_q <= bI + xI;
            yQ_q <= bQ + xQ;
        end else if (emit_i) begin
            yI_q <= bI;
            yQ_q <= bQ;
        end
    end

    assign yI_o = yI_q;
    assign yQ_o = yQ_q;
endmodule

// File: rtl/fft_bfly_sdf_stage.sv
// Radix-2 SDF butterfly stage: beat counter, run/flush control and ARRAY_IN parallel lanes.
module fft_bfly_sdf_stage #(
    parameter int WIDTH_IN  = fft_pkg::CBFP0_WIDTH_OUT,
    parameter int WIDTH_OUT = WIDTH_IN + 1,
    parameter int ARRAY_IN  = fft_pkg::ARRAY_IN,
    parameter int D_CLK     = 4,
    parameter int FRAME_CLK = fft_pkg::FRAME_CLK
) (
    input  logic clk,
    input  logic rst_n,
    fft_bfly_sdf_stage_if.slave bus
);
    import fft_pkg::*;

    localparam int FW = $clog2(FRAME_CLK);
    localparam int SW = slotBits(D_CLK);
    localparam int PB = $clog2(D_CLK);

    bfly_state_e   state_q, state_d;
    logic [FW-1:0] bcnt_q, bcnt_d;
    logic          pending_q, pending_d;
    logic          outValid_q, outValid_d;
    logic          frameDone_q, frameDone_d;
    logic          phase, lastSlot, flushing, beatP1, emit;
    logic [SW-1:0] slot;

    logic signed [WIDTH_OUT-1:0] laneI [ARRAY_IN];
    logic signed [WIDTH_OUT-1:0] laneQ [ARRAY_IN];

    assign phase    = bcnt_q[PB];
    assign slot     = bcnt_q[SW-1:0] & SW'(D_CLK - 1);
    assign lastSlot = (slot == SW'(D_CLK - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.i_valid) state_d = RUN;
            RUN:     if (flushing) state_d = lastSlot ? IDLE : FLUSH;
            FLUSH: begin
                if (bus.i_valid)   state_d = RUN;
                else if (lastSlot) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A gap right after the frame wrap starts the drain in that same cycle, so the tail leaves D_CLK+1 after the last beat.
    always_comb begin
        flushing = 1'b0;
        if (!bus.i_valid)
            flushing = (state_q == FLUSH) ||
                       (state_q == RUN && bcnt_q == '0 && pending_q);
        beatP1 = bus.i_valid && phase;
        emit   = flushing || (bus.i_valid && !phase && pending_q);
    end

    always_comb begin
        bcnt_d    = bcnt_q;
        pending_d = pending_q;
        if (flushing && lastSlot)        bcnt_d = '0;
        else if (bus.i_valid || flushing) bcnt_d = bcnt_q + 1'b1;
        if (beatP1)                      pending_d = 1'b1;
        else if (emit && lastSlot)       pending_d = 1'b0;
        outValid_d  = emit || beatP1;
        frameDone_d = emit && (bcnt_q == FW'(D_CLK - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcnt_q      <= '0;
            pending_q   <= 1'b0;
            outValid_q  <= 1'b0;
            frameDone_q <= 1'b0;
        end else begin
            bcnt_q      <= bcnt_d;
            pending_q   <= pending_d;
            outValid_q  <= outValid_d;
            frameDone_q <= frameDone_d;
        end
    end

    for (genvar k = 0; k < ARRAY_IN; k++) begin : g_lane
        fft_bfly_lane #(
            .WIDTH_IN (WIDTH_IN),
            .WIDTH_OUT(WIDTH_OUT),
            .D_CLK    (D_CLK),
            .SW       (SW)
        ) u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .phase_i(phase),
            .slot_i (slot),
            .valid_i(bus.i_valid),
            .emit_i (emit),
            .xI_i   (bus.din_i[k]),
            .xQ_i   (bus.din_q[k]),
            .yI_o   (laneI[k]),
            .yQ_o   (laneQ[k])
        );
    end

    assign bus.dout_i     = laneI;
    assign bus.dout_q     = laneQ;
    assign bus.dout_valid = outValid_q;
    assign bus.frame_done = frameDone_q;
endmodule
